// File: rtl/seq_pattern_gen_if.sv
// Handshake/data bundle between a pattern source and seq_pattern_gen.
// master drives the request side; slave (the generator) drives the serial stream and status.
interface seq_pattern_gen_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5,
  parameter int CNT_W = 8
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [3:0]       rpt;
  logic             X;
  logic             x_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] exp_count;

  modport master (
    output start, pattern, len, rpt,
    input  X, x_valid, busy, done, exp_count
  );

  modport slave (
    input  start, pattern, len, rpt,
    output X, x_valid, busy, done, exp_count
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial test-pattern transmitter: sends a captured word MSB-first for rpt+1 passes
// and counts overlapping "101" occurrences in the emitted stream.
module seq_pattern_gen #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  seq_pattern_gen_if.slave bus
);
  localparam int               IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] pat_q;
  logic [IDX_W-1:0] last_idx_q;
  logic [IDX_W-1:0] idx;
  logic [3:0]       rpt_q;
  logic [3:0]       pass;
  logic [1:0]       recent;
  logic [2:0]       hist_now;
  logic [IDX_W-1:0] start_idx;
  logic             len_ok;

  // The two previously emitted bits plus the bit on X form the 3-bit history.
  assign hist_now  = {recent, bus.X};
  assign len_ok    = (bus.len != '0) && (bus.len <= MAX_LEN);
  assign start_idx = IDX_W'(bus.len - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pat_q         <= '0;
      last_idx_q    <= '0;
      idx           <= '0;
      rpt_q         <= '0;
      pass          <= '0;
      recent        <= '0;
      bus.X         <= 1'b0;
      bus.x_valid   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.exp_count <= '0;
    end else begin
      // Count a bit once its valid cycle completes, so exp_count lags X by one edge.
      if (bus.x_valid) begin
        recent <= hist_now[1:0];
        if (hist_now == 3'b101 && bus.exp_count != CNT_MAX)
          bus.exp_count <= bus.exp_count + 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.start && len_ok) begin
            pat_q         <= bus.pattern;
            last_idx_q    <= start_idx;
            rpt_q         <= bus.rpt;
            idx           <= start_idx;
            pass          <= '0;
            recent        <= '0;
            bus.exp_count <= '0;
            bus.X         <= bus.pattern[start_idx];
            bus.x_valid   <= 1'b1;
            bus.busy      <= 1'b1;
            state         <= SHIFT;
          end
        end
        SHIFT: begin
          if (idx != '0) begin
            idx   <= idx - 1'b1;
            bus.X <= pat_q[idx - 1'b1];
          end else if (pass != rpt_q) begin
            // Wrap back to the MSB for another pass; history carries across the seam.
            pass  <= pass + 1'b1;
            idx   <= last_idx_q;
            bus.X <= pat_q[last_idx_q];
          end else begin
            bus.X       <= 1'b0;
            bus.x_valid <= 1'b0;
            bus.done    <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: a stream-level model builds the expected per-cycle trajectory
// of each transfer, and a negedge process compares two DUTs (8-bit and 2-bit counters) against it.
module tb_seq_pattern_gen;
  localparam int WIDTH = 16;
  localparam int LEN_W = 5;
  localparam int CNT_W = 8;
  localparam int SAT_W = 2;

  typedef struct {
    logic x;
    logic xv;
    logic busy;
    logic done;
    int   cnt;
    int   cnt_sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   idle_cnt = 0;
  int   idle_cnt_sat = 0;
  logic [31:0] obs;
  int   done_cycle;
  int   nvalid;

  always #5 clk = ~clk;

  seq_pattern_gen_if #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();
  seq_pattern_gen_if #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(SAT_W)) sat_bus ();

  assign sat_bus.start   = bus.start;
  assign sat_bus.pattern = bus.pattern;
  assign sat_bus.len     = bus.len;
  assign sat_bus.rpt     = bus.rpt;

  seq_pattern_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  seq_pattern_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(SAT_W)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sat_bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int satv(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  // Outside a transfer the outputs must sit idle holding the last final count.
  always @(negedge clk) begin : compare
    exp_t e;
    if (exp_q.size() > 0) begin
      e            = exp_q.pop_front();
      idle_cnt     = e.cnt;
      idle_cnt_sat = e.cnt_sat;
    end else begin
      e.x       = 1'b0;
      e.xv      = 1'b0;
      e.busy    = 1'b0;
      e.done    = 1'b0;
      e.cnt     = idle_cnt;
      e.cnt_sat = idle_cnt_sat;
    end
    checkOutput("cyc_X",         32'(bus.X),             32'(e.x));
    checkOutput("cyc_x_valid",   32'(bus.x_valid),       32'(e.xv));
    checkOutput("cyc_busy",      32'(bus.busy),          32'(e.busy));
    checkOutput("cyc_done",      32'(bus.done),          32'(e.done));
    checkOutput("cyc_exp_count", 32'(bus.exp_count),     32'(e.cnt));
    checkOutput("cyc_sat_count", 32'(sat_bus.exp_count), 32'(e.cnt_sat));
    checkOutput("cyc_sat_X",     32'(sat_bus.X),         32'(e.x));
  end

  // One accepted transfer: build the expected stream, then walk its N+1 cycles.
  task automatic applyStimulus(input logic [15:0] pat, input int ln, input int rp,
                               input bit disturb, input int abort_at);
    bit   s[$];
    int   n, occ, k_dist;
    exp_t e;
    @(posedge clk); #1;
    bus.pattern = pat;
    bus.len     = LEN_W'(ln);
    bus.rpt     = 4'(rp);
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int p = 0; p <= rp; p++)
      for (int i = ln - 1; i >= 0; i--)
        s.push_back(pat[i]);
    n   = s.size();
    occ = 0;
    for (int k = 1; k <= n; k++) begin
      e.x = s[k-1]; e.xv = 1'b1; e.busy = 1'b1; e.done = 1'b0;
      e.cnt = satv(occ, CNT_W); e.cnt_sat = satv(occ, SAT_W);
      exp_q.push_back(e);
      if (k >= 3 && s[k-3] == 1'b1 && s[k-2] == 1'b0 && s[k-1] == 1'b1) occ++;
    end
    e.x = 1'b0; e.xv = 1'b0; e.busy = 1'b1; e.done = 1'b1;
    e.cnt = satv(occ, CNT_W); e.cnt_sat = satv(occ, SAT_W);
    exp_q.push_back(e);

    k_dist = (disturb && n >= 2) ? int'($urandom_range(1, n - 1)) : 0;
    obs = '0; done_cycle = 0; nvalid = 0;
    for (int j = 1; j <= n + 1; j++) begin
      if (bus.x_valid) begin
        obs = {obs[30:0], bus.X};
        nvalid++;
      end
      if (bus.done) done_cycle = j;
      if (j == abort_at) begin
        #1;
        rst = 1'b1;
        exp_q.delete();
        idle_cnt = 0;
        idle_cnt_sat = 0;
        #1;
        checkOutput("rst_X",         32'(bus.X),         0);
        checkOutput("rst_x_valid",   32'(bus.x_valid),   0);
        checkOutput("rst_busy",      32'(bus.busy),      0);
        checkOutput("rst_done",      32'(bus.done),      0);
        checkOutput("rst_exp_count", 32'(bus.exp_count), 0);
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b0;
        return;
      end
      if (j == k_dist) begin
        bus.start   = 1'b1;
        bus.pattern = 16'($urandom);
        bus.len     = 5'($urandom_range(0, 31));
        bus.rpt     = 4'($urandom);
      end
      if (k_dist != 0 && j == k_dist + 1) bus.start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic applyIllegal(input int ln);
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1;
    bus.pattern = 16'h0005;
    bus.len     = LEN_W'(ln);
    bus.rpt     = 4'd0;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      seen = seen | bus.busy | bus.x_valid | bus.done;
      @(posedge clk); #1;
    end
    checkOutput($sformatf("illegal_len_%0d", ln), 32'(seen), 0);
  endtask

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.len     = '0;
    bus.rpt     = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    checkOutput("reset_busy",      32'(bus.busy),      0);
    checkOutput("reset_exp_count", 32'(bus.exp_count), 0);

    applyStimulus(16'h0005, 3, 0, 1'b0, 0);
    checkOutput("basic_bits",  32'(obs[2:0]),         32'b101);
    checkOutput("basic_done",  32'(done_cycle),       4);
    checkOutput("basic_count", 32'(bus.exp_count),    1);

    applyStimulus(16'h0015, 5, 0, 1'b0, 0);
    checkOutput("overlap_bits",  32'(obs[4:0]),      32'b10101);
    checkOutput("overlap_valid", 32'(nvalid),        5);
    checkOutput("overlap_count", 32'(bus.exp_count), 2);

    applyStimulus(16'h0002, 2, 2, 1'b0, 0);
    checkOutput("wrap_bits",  32'(obs[5:0]),      32'b101010);
    checkOutput("wrap_done",  32'(done_cycle),    7);
    checkOutput("wrap_count", 32'(bus.exp_count), 2);

    applyIllegal(0);
    applyIllegal(17);

    applyStimulus(16'h00B3, 8, 1, 1'b1, 0);
    checkOutput("busy_start_valid", 32'(nvalid), 16);

    applyStimulus(16'hA5A5, 16, 1, 1'b0, 6);
    applyStimulus(16'h0005, 3, 0, 1'b0, 0);
    checkOutput("post_rst_count", 32'(bus.exp_count), 1);

    applyStimulus(16'h0002, 2, 15, 1'b0, 0);
    checkOutput("sat_valid",     32'(nvalid),            32);
    checkOutput("sat_bits",      obs,                    32'hAAAAAAAA);
    checkOutput("sat_full_cnt",  32'(bus.exp_count),     15);
    checkOutput("sat_small_cnt", 32'(sat_bus.exp_count), 3);

    for (int t = 0; t < 24; t++)
      applyStimulus(16'($urandom), int'($urandom_range(1, WIDTH)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
